// File: rtl/mul_pkg.sv
// Shared types and defaults for the repeated-addition multiplier controller.
package mul_pkg;

    localparam int MUL_W        = 16;
    localparam int MUL_MAX_ITER = 65535;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } mul_state_e;

endpackage

// File: rtl/mul_iter_cnt.sv
// Add-cycle counter for the watchdog; term_o flags the last permitted add.
module mul_iter_cnt
    import mul_pkg::*;
#(
    parameter int W        = MUL_W,
    parameter int MAX_ITER = MUL_MAX_ITER
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == W'(MAX_ITER - 1));

endmodule

// File: rtl/mul_ctrl.sv
// Start/busy/done sequencer for the repeated-addition multiplier datapath,
// with operand latches, operand bus mux and a stall watchdog.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int W        = MUL_W,
    parameter int MAX_ITER = MUL_MAX_ITER
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         eqz,
    output logic [W-1:0] bus,
    output logic         lda,
    output logic         ldb,
    output logic         clrp,
    output logic         ldp,
    output logic         dreb,
    output logic         busy,
    output logic         done,
    output logic         err
);

    // state  | meaning
    // IDLE   | waiting for start, outputs quiet
    // LOAD_A | multiplicand on bus, lda
    // LOAD_B | multiplier on bus, ldb + clrp
    // RUN    | one add per cycle until eqz or watchdog
    // DONE   | one-cycle done pulse
    // ERR    | watchdog tripped, err becomes sticky

    mul_state_e   state_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         lda_q;
    logic         ldb_q;
    logic         clrp_q;
    logic         busy_q;
    logic         done_q;
    logic         err_q;

    logic         run;
    logic         accept;
    logic         term;

    assign run    = (state_q == S_RUN);
    assign accept = (state_q == S_IDLE) && start;

    mul_iter_cnt #(
        .W        (W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (accept),
        .en_i   (run && !eqz && !term),
        .term_o (term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            lda_q   <= 1'b0;
            ldb_q   <= 1'b0;
            clrp_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            lda_q  <= 1'b0;
            ldb_q  <= 1'b0;
            clrp_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        err_q   <= 1'b0;
                        lda_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    ldb_q   <= 1'b1;
                    clrp_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    busy_q  <= 1'b1;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    // eqz wins over the watchdog: a finished multiply is never an error
                    if (eqz) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (term) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus  = lda_q ? a_q : (ldb_q ? b_q : '0);
    assign lda  = lda_q;
    assign ldb  = ldb_q;
    assign clrp = clrp_q;
    assign ldp  = run && !eqz;
    assign dreb = run && !eqz;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: behavioural datapath plus product/latency/pulse-count reference.
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        eqz;
    logic [15:0] bus;
    logic        lda, ldb, clrp, ldp, dreb, busy, done, err;

    logic        start_wd = 1'b0;
    logic [15:0] bus_wd;
    logic        lda_wd, ldb_wd, clrp_wd, ldp_wd, dreb_wd, busy_wd, done_wd, err_wd;

    int errors = 0;
    int checks = 0;

    // behavioural datapath driven by the strobes
    logic [15:0] dp_a = '0;
    logic [15:0] dp_b = '0;
    logic [15:0] dp_p = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lda) dp_a <= bus;
        if (ldb) dp_b <= bus;
        else if (dreb) dp_b <= dp_b - 16'd1;
        if (clrp) dp_p <= '0;
        else if (ldp) dp_p <= dp_p + dp_a;
    end
    assign eqz = (dp_b == 16'd0);

    mul_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .eqz(eqz),
        .bus(bus), .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp), .dreb(dreb),
        .busy(busy), .done(done), .err(err)
    );

    mul_ctrl #(.W(16), .MAX_ITER(4)) dut_wd (
        .clk(clk), .rst_n(rst_n), .start(start_wd), .a_in(16'h1234), .b_in(16'h0005), .eqz(1'b0),
        .bus(bus_wd), .lda(lda_wd), .ldb(ldb_wd), .clrp(clrp_wd), .ldp(ldp_wd), .dreb(dreb_wd),
        .busy(busy_wd), .done(done_wd), .err(err_wd)
    );

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus, lda, ldb, clrp, ldp, dreb, busy, done, err} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {bus, lda, ldb, clrp, ldp, dreb, busy, done, err});
        end
        checks++;
        if ({bus_wd, lda_wd, ldb_wd, clrp_wd, ldp_wd, dreb_wd, busy_wd, done_wd, err_wd} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs_wd got=%h want=0",
                     {bus_wd, lda_wd, ldb_wd, clrp_wd, ldp_wd, dreb_wd, busy_wd, done_wd, err_wd});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One multiply; returns at the negedge of the done cycle (or after the time budget).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] exp_p;
        int pulses, lat, strobe_skew, limit;
        logic seen;
        exp_p = 16'(32'(a) * 32'(b));
        pulses = 0; lat = 0; strobe_skew = 0; seen = 1'b0;
        limit = int'(b) + 30;
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b;
        @(posedge clk);
        #1 start = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom);
        for (int n = 1; n <= limit && !seen; n++) begin
            @(negedge clk);
            if (ldp) pulses++;
            if (ldp !== dreb) strobe_skew++;
            if (n == 1) begin
                checks++;
                if ({lda, ldb, busy, bus} !== {1'b1, 1'b0, 1'b1, a}) begin
                    errors++;
                    $display("FAIL load_a got lda=%b ldb=%b busy=%b bus=%h want 1 0 1 %h", lda, ldb, busy, bus, a);
                end
            end
            if (n == 2) begin
                checks++;
                if ({lda, ldb, clrp, busy, bus} !== {1'b0, 1'b1, 1'b1, 1'b1, b}) begin
                    errors++;
                    $display("FAIL load_b got lda=%b ldb=%b clrp=%b busy=%b bus=%h want 0 1 1 1 %h",
                             lda, ldb, clrp, busy, bus, b);
                end
            end
            if (done) begin
                seen = 1'b1;
                lat = n;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout a=%h b=%h got no done within %0d cycles", a, b, limit);
        end
        checks++;
        if (seen && lat != int'(b) + 4) begin
            errors++;
            $display("FAIL done_latency a=%h b=%h got=%0d want=%0d", a, b, lat, int'(b) + 4);
        end
        checks++;
        if (pulses != int'(b)) begin
            errors++;
            $display("FAIL ldp_pulses a=%h b=%h got=%0d want=%0d", a, b, pulses, int'(b));
        end
        checks++;
        if (strobe_skew != 0) begin
            errors++;
            $display("FAIL ldp_dreb_equal got=%0d differing cycles want=0", strobe_skew);
        end
        checks++;
        if (dp_p !== exp_p) begin
            errors++;
            $display("FAIL product a=%h b=%h got=%h want=%h", a, b, dp_p, exp_p);
        end
        checks++;
        if ({err, busy} !== 2'b00) begin
            errors++;
            $display("FAIL done_flags got err=%b busy=%b want 0 0", err, busy);
        end
    endtask

    task automatic test_directed();
        run_op(16'd5, 16'd3);
        run_op(16'd9, 16'd0);
        run_op(16'hFFFF, 16'd2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_op(16'($urandom), 16'($urandom_range(0, 20)));
        end
    endtask

    // run_op returns in the DONE cycle, so the next start lands on the first IDLE edge
    task automatic test_back_to_back();
        run_op(16'd7, 16'd1);
        run_op(16'd11, 16'd6);
        run_op(16'h8000, 16'd3);
    endtask

    task automatic test_start_held();
        int accepts;
        logic [15:0] bus10;
        logic lda10;
        logic seen;
        accepts = 0;
        @(negedge clk);
        start = 1'b1; a_in = 16'd2; b_in = 16'd4;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            #1;
            if (n <= 8) begin
                a_in = 16'($urandom); b_in = 16'($urandom_range(20, 60));
            end
            @(negedge clk);
            if (n <= 9 && lda) accepts++;
            if (n == 8) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL held_done got=%b want=1 at cycle 8", done);
                end
                checks++;
                if (dp_p !== 16'd8) begin
                    errors++;
                    $display("FAIL held_product got=%h want=0008", dp_p);
                end
            end
            if (n == 9) begin
                a_in = 16'd7; b_in = 16'd1;
            end
            if (n == 10) begin
                lda10 = lda; bus10 = bus;
            end
            if (n < 10) @(posedge clk);
        end
        checks++;
        if (accepts != 1) begin
            errors++;
            $display("FAIL held_single_accept got=%0d want=1", accepts);
        end
        checks++;
        if ({lda10, bus10} !== {1'b1, 16'd7}) begin
            errors++;
            $display("FAIL held_reaccept got lda=%b bus=%h want 1 0007", lda10, bus10);
        end
        start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen || dp_p !== 16'd7) begin
            errors++;
            $display("FAIL held_second_run got seen=%b product=%h want 1 0007", seen, dp_p);
        end
    endtask

    task automatic test_watchdog();
        int pulses, dones, first_err;
        pulses = 0; dones = 0; first_err = 0;
        @(negedge clk);
        start_wd = 1'b1;
        @(posedge clk);
        #1 start_wd = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (ldp_wd) pulses++;
            if (done_wd) dones++;
            if (err_wd && first_err == 0) first_err = n;
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL wd_pulses got=%0d want=4", pulses);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL wd_no_done got=%0d want=0", dones);
        end
        checks++;
        if (first_err != 7) begin
            errors++;
            $display("FAIL wd_err_cycle got=%0d want=7", first_err);
        end
        checks++;
        if ({err_wd, busy_wd} !== 2'b10) begin
            errors++;
            $display("FAIL wd_sticky got err=%b busy=%b want 1 0", err_wd, busy_wd);
        end
        @(negedge clk);
        start_wd = 1'b1;
        @(posedge clk);
        #1 start_wd = 1'b0;
        @(negedge clk);
        checks++;
        if ({err_wd, lda_wd} !== 2'b01) begin
            errors++;
            $display("FAIL wd_err_clear got err=%b lda=%b want 0 1", err_wd, lda_wd);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start = 1'b1; a_in = 16'd3; b_in = 16'd10;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({ldp, busy} !== 2'b11) begin
            errors++;
            $display("FAIL midrun_active got ldp=%b busy=%b want 1 1", ldp, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus, lda, ldb, clrp, ldp, dreb, busy, done, err} !== 24'h0) begin
            errors++;
            $display("FAIL midrun_reset got=%h want=0", {bus, lda, ldb, clrp, ldp, dreb, busy, done, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd3, 16'd2);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_held();
        test_watchdog();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
